bcd_stopwatch_core: RTL and testbench

- Upstream stage of the 4-digit multiplexed seven-segment display driver.
- Prescales the system clock into count ticks and keeps a 4-digit BCD up-counter, 0000-9999.
- Runs a run/pause/lap/clear control state machine driven by single-cycle-edge-detected button inputs.
- Presents 16 bits of BCD plus a decimal-point mask, which the display driver multiplexes onto AN0-AN3 and CA-CG/DP.

---
 rtl/bcd_stopwatch_core.sv | 156 +++++++++++++++
 tb/tb_bcd_stopwatch_core.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_core.sv
// Stopwatch core: prescaled 4-digit BCD up-counter with run/pause/lap/clear control.
// Feeds 16 bits of BCD plus a decimal-point mask to the multiplexed display driver.
module bcd_stopwatch_core #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned DP_POS   = 2
) (
  input  logic        i_w_clk,
  input  logic        i_w_reset,
  input  logic        i_w_start_stop,
  input  logic        i_w_clear,
  input  logic        i_w_lap,
  output logic [15:0] o_r_digits,
  output logic [3:0]  o_r_dp_mask,
  output logic        o_r_running,
  output logic        o_r_wrap
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLap,
    StPause
  } state_e;

  localparam logic [15:0] TickMax = 16'(TICK_DIV - 1);
  localparam logic [3:0]  DpMask  = 4'(1 << DP_POS);

  state_e      state_q;
  logic [15:0] presc_q;
  logic [15:0] count_q;
  logic [15:0] snap_q;
  logic [15:0] digits_q;
  logic        running_q;
  logic        wrap_q;
  logic        ss_prev_q;
  logic        clr_prev_q;
  logic        lap_prev_q;

  logic        ss_edge;
  logic        clr_edge;
  logic        lap_edge;
  logic        active;
  logic        tick;
  logic        all_nines;
  logic [15:0] count_inc;
  logic        carry;

  always_comb begin
    ss_edge   = i_w_start_stop & ~ss_prev_q;
    clr_edge  = i_w_clear & ~clr_prev_q;
    lap_edge  = i_w_lap & ~lap_prev_q;
    active    = (state_q == StRun) || (state_q == StLap);
    tick      = active && (presc_q == TickMax);
    all_nines = (count_q == 16'h9999);
  end

  // Ripple BCD increment: a 9 rolls to 0 and passes the carry upward.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state_q    <= StIdle;
      presc_q    <= 16'd0;
      count_q    <= 16'd0;
      snap_q     <= 16'd0;
      digits_q   <= 16'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      // History starts high so a button held through reset produces no edge.
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
      lap_prev_q <= 1'b1;
    end else begin
      ss_prev_q  <= i_w_start_stop;
      clr_prev_q <= i_w_clear;
      lap_prev_q <= i_w_lap;
      wrap_q     <= 1'b0;
      digits_q   <= (state_q == StLap) ? snap_q : count_q;

      if (clr_edge) begin
        state_q   <= StIdle;
        presc_q   <= 16'd0;
        count_q   <= 16'd0;
        snap_q    <= 16'd0;
        running_q <= 1'b0;
      end else begin
        if (active) begin
          presc_q <= tick ? 16'd0 : presc_q + 16'd1;
        end else if (state_q == StIdle) begin
          presc_q <= 16'd0;
        end

        // A tick coinciding with start_stop still lands before the state change.
        if (tick) begin
          count_q <= count_inc;
          wrap_q  <= all_nines;
        end

        case (state_q)
          StIdle: begin
            if (ss_edge) begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          StRun: begin
            if (ss_edge) begin
              state_q   <= StPause;
              running_q <= 1'b0;
            end else if (lap_edge) begin
              state_q <= StLap;
              snap_q  <= count_q;
            end
          end
          StLap: begin
            if (ss_edge) begin
              state_q   <= StPause;
              running_q <= 1'b0;
            end else if (lap_edge) begin
              state_q <= StRun;
            end
          end
          StPause: begin
            if (ss_edge) begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_r_digits  = digits_q;
  assign o_r_dp_mask = DpMask;
  assign o_r_running = running_q;
  assign o_r_wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Bench for bcd_stopwatch_core: table of button steps with scoreboarded expectations,
// plus hand sequences for reset, 9999 rollover and asynchronous reset.
module tb_bcd_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss;
  logic        clr;
  logic        lap;
  logic [15:0] o_r_digits;
  logic [3:0]  o_r_dp_mask;
  logic        o_r_running;
  logic        o_r_wrap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_core #(
    .TICK_DIV(4),
    .DP_POS  (2)
  ) dut (
    .i_w_clk       (clk),
    .i_w_reset     (rst_n),
    .i_w_start_stop(ss),
    .i_w_clear     (clr),
    .i_w_lap       (lap),
    .o_r_digits    (o_r_digits),
    .o_r_dp_mask   (o_r_dp_mask),
    .o_r_running   (o_r_running),
    .o_r_wrap      (o_r_wrap)
  );

  typedef struct {
    logic        s;
    logic        c;
    logic        l;
    int          w;
    logic [15:0] dig;
    logic        run;
  } step_t;

  typedef struct {
    logic [15:0] dig;
    logic        run;
  } exp_t;

  step_t steps[17];
  exp_t  sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Buttons are driven at a falling edge, sampled on the next rising edge, then released.
  task automatic press(input logic s, input logic c, input logic l);
    ss  = s;
    clr = c;
    lap = l;
    @(negedge clk);
    ss  = 1'b0;
    clr = 1'b0;
    lap = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   wrap_cnt;
    int   wrap_at;
    int   bad_bcd;

    // {start, clear, lap, extra cycles after press, expected digits, expected running}
    steps[0]  = '{1'b1, 1'b0, 1'b0, 40, 16'h0009, 1'b1};
    steps[1]  = '{1'b0, 1'b0, 1'b0,  0, 16'h0010, 1'b1};
    steps[2]  = '{1'b1, 1'b0, 1'b0, 20, 16'h0010, 1'b0};
    steps[3]  = '{1'b1, 1'b0, 1'b0,  3, 16'h0011, 1'b1};
    steps[4]  = '{1'b0, 1'b0, 1'b1, 20, 16'h0011, 1'b1};
    steps[5]  = '{1'b0, 1'b0, 1'b1,  1, 16'h0016, 1'b1};
    steps[6]  = '{1'b0, 1'b0, 1'b1,  8, 16'h0017, 1'b1};
    steps[7]  = '{1'b1, 1'b0, 1'b0,  4, 16'h0019, 1'b0};
    steps[8]  = '{1'b1, 1'b0, 1'b0,  0, 16'h0019, 1'b1};
    steps[9]  = '{1'b1, 1'b1, 1'b0,  2, 16'h0000, 1'b0};
    steps[10] = '{1'b0, 1'b0, 1'b1, 10, 16'h0000, 1'b0};
    steps[11] = '{1'b1, 1'b0, 1'b0,  5, 16'h0001, 1'b1};
    steps[12] = '{1'b1, 1'b0, 1'b1,  3, 16'h0001, 1'b0};
    steps[13] = '{1'b0, 1'b1, 1'b0,  1, 16'h0000, 1'b0};
    steps[14] = '{1'b1, 1'b0, 1'b0,  3, 16'h0000, 1'b1};
    steps[15] = '{1'b1, 1'b0, 1'b0,  2, 16'h0001, 1'b0};
    steps[16] = '{1'b0, 1'b1, 1'b0,  1, 16'h0000, 1'b0};

    // Reset with start_stop held high across release.
    rst_n = 1'b0;
    ss    = 1'b1;
    clr   = 1'b0;
    lap   = 1'b0;
    repeat (10) @(negedge clk);
    check("reset digits", {16'h0, o_r_digits}, 32'h0);
    check("reset running", {31'h0, o_r_running}, 32'h0);
    check("reset wrap", {31'h0, o_r_wrap}, 32'h0);
    check("reset dp_mask", {28'h0, o_r_dp_mask}, 32'h4);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("held start no edge running", {31'h0, o_r_running}, 32'h0);
    check("held start no edge digits", {16'h0, o_r_digits}, 32'h0);
    ss = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      sb.push_back('{steps[i].dig, steps[i].run});
      press(steps[i].s, steps[i].c, steps[i].l);
      repeat (steps[i].w) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("step%0d digits", i), {16'h0, o_r_digits}, {16'h0, e.dig});
      check($sformatf("step%0d running", i), {31'h0, o_r_running}, {31'h0, e.run});
    end

    // Count from 0000 through the 9999 -> 0000 rollover.
    press(1'b1, 1'b0, 1'b0);
    wrap_cnt = 0;
    wrap_at  = 0;
    bad_bcd  = 0;
    for (int j = 1; j <= 40003; j++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (o_r_digits[4*k +: 4] > 4'd9) bad_bcd++;
      end
      if (o_r_wrap) begin
        wrap_cnt++;
        wrap_at = j;
      end
      if (j == 39996) check("digits 9998", {16'h0, o_r_digits}, 32'h9998);
      if (j == 40000) check("digits 9999", {16'h0, o_r_digits}, 32'h9999);
      if (j == 40001) check("digits after wrap", {16'h0, o_r_digits}, 32'h0);
      if (j == 40003) check("running after wrap", {31'h0, o_r_running}, 32'h1);
    end
    check("wrap pulse count", wrap_cnt, 32'd1);
    check("wrap pulse cycle", wrap_at, 32'd40000);
    check("digits stay bcd", bad_bcd, 32'd0);

    // Asynchronous reset between clock edges while counting at 0042.
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (169) @(negedge clk);
    check("pre-reset digits", {16'h0, o_r_digits}, 32'h0042);
    check("pre-reset running", {31'h0, o_r_running}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset digits", {16'h0, o_r_digits}, 32'h0);
    check("async reset running", {31'h0, o_r_running}, 32'h0);
    check("async reset dp_mask", {28'h0, o_r_dp_mask}, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post-reset idle digits", {16'h0, o_r_digits}, 32'h0);
    check("post-reset idle running", {31'h0, o_r_running}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
